// File: rtl/damage_controller.sv
// damage_controller: per-frame hit resolution, status mirrors and round FSM (in: clk, reset, frame_tick, start, pN_hit_req/blocked; out: pN_stunmode, status_reset, pN_health/block, game_over, winner, fighting)
module damage_controller #(
    parameter int HIT_COOLDOWN    = 8,
    parameter int ROUND_END_DELAY = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       p1_hit_req,
    input  logic       p1_hit_blocked,
    input  logic       p2_hit_req,
    input  logic       p2_hit_blocked,
    output logic [1:0] p1_stunmode,
    output logic [1:0] p2_stunmode,
    output logic       status_reset,
    output logic [1:0] p1_health,
    output logic [1:0] p2_health,
    output logic [1:0] p1_block,
    output logic [1:0] p2_block,
    output logic       game_over,
    output logic [1:0] winner,
    output logic       fighting
);
    typedef enum logic [1:0] {FIGHT, KO_DELAY, GAME_OVER, CLEAR} state_t;
    state_t state;
    logic [1:0][1:0] h, b, stun, nh, nb, nstun;
    logic [1:0][3:0] cd, ncd;
    logic [1:0] pend, unblk, req, blk, unb, hit, guard;
    logic [7:0] dly;
    logic act;
    assign req = {p2_hit_req, p1_hit_req};
    assign blk = {p2_hit_blocked, p1_hit_blocked};
    always_comb begin
        act = (state == FIGHT) && frame_tick;
        for (int i = 0; i < 2; i++) begin
            unb[i]   = unblk[i] | (req[i] & ~blk[i]);
            hit[i]   = act & (pend[i] | req[i]) & (cd[i] == 4'd0);
            guard[i] = hit[i] & ~unb[i] & (b[i] != 2'd0);
            nb[i]    = b[i] - {1'b0, guard[i]};
            nh[i]    = h[i] - {1'b0, hit[i] & ~guard[i] & (h[i] != 2'd0)};
            nstun[i] = hit[i] ? (guard[i] ? 2'b10 : 2'b01) : 2'b00;
            ncd[i]   = hit[i] ? 4'(HIT_COOLDOWN) : (act && cd[i] != 4'd0) ? cd[i] - 4'd1 : cd[i];
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= FIGHT;
            h      <= '1;
            b      <= '1;
            cd     <= '0;
            pend   <= '0;
            unblk  <= '0;
            stun   <= '0;
            winner <= 2'b00;
            dly    <= '0;
        end else begin
            stun <= nstun;
            h    <= nh;
            b    <= nb;
            cd   <= ncd;
            if (state == FIGHT) begin
                pend  <= frame_tick ? '0 : pend | req;
                unblk <= frame_tick ? '0 : unblk | (req & ~blk);
            end
            case (state)
                FIGHT: if (act && (nh[0] == 2'd0 || nh[1] == 2'd0)) begin
                    state  <= KO_DELAY;
                    winner <= {nh[0] == 2'd0, nh[1] == 2'd0};
                    dly    <= 8'(ROUND_END_DELAY);
                end
                KO_DELAY: if (frame_tick) begin
                    dly <= dly - 8'd1;
                    if (dly == 8'd1) state <= GAME_OVER;
                end
                GAME_OVER: if (start) state <= CLEAR;
                default: begin
                    h      <= '1;
                    b      <= '1;
                    cd     <= '0;
                    pend   <= '0;
                    unblk  <= '0;
                    winner <= 2'b00;
                    state  <= FIGHT;
                end
            endcase
        end
    end
    assign p1_stunmode  = stun[0];
    assign p2_stunmode  = stun[1];
    assign p1_health    = h[0];
    assign p2_health    = h[1];
    assign p1_block     = b[0];
    assign p2_block     = b[1];
    assign game_over    = state == GAME_OVER;
    assign fighting     = state == FIGHT;
    assign status_reset = state == CLEAR;
endmodule

// File: doc/damage_controller.md
# damage_controller

Sequencing controller for the player status shift registers (health and block, three cells each, per player). It collects hit events from collision logic and resolves them once per game frame. Each resolved event becomes a single-cycle `stunmode` pulse, so a status register shifts exactly one cell per hit. The block also mirrors the remaining counts to enforce guard-break, invulnerability cooldown and KO, and runs the round FSM, which includes the status reload for a new round.

## Interface
- `HIT_COOLDOWN`, 8: frame ticks of invulnerability after a resolved hit on a player; range 0..15.
- `ROUND_END_DELAY`, 60: frame ticks between KO detection and `game_over`; range 1..255.
- `clk` in 1: system clock.
- `reset` in 1: reset is synchronous and active-high.
- `frame_tick` in 1: one-cycle pulse per game frame.
- `start` in 1: one-cycle pulse that starts a new round from GAME_OVER.
- `p1_hit_req` in 1: P1 was struck this cycle.
- `p1_hit_blocked` in 1: qualifies `p1_hit_req`; P1 was guarding.
- `p2_hit_req` in 1: P2 was struck this cycle.
- `p2_hit_blocked` in 1: qualifies `p2_hit_req`; P2 was guarding.
- `p1_stunmode` out 2: drives P1 status; 00 none, 01 hurt, 10 blocked; pulses for one cycle only.
- `p2_stunmode` out 2: drives P2 status; same encoding.
- `status_reset` out 1: one-cycle pulse that reloads the status registers to full.
- `p1_health`, `p2_health` out 2: mirrored health, 0..3.
- `p1_block`, `p2_block` out 2: mirrored block, 0..3.
- `game_over` out 1: high in GAME_OVER.
- `winner` out 2: 00 none, 01 P1, 10 P2, 11 draw.
- `fighting` out 1: high in FIGHT.

## Operation
- FSM states: FIGHT, KO_DELAY, GAME_OVER, CLEAR.
- Reset values:
  - state FIGHT;
  - health and block counts 3;
  - cooldowns 0;
  - pending flags 0;
  - all stunmode 00;
  - `status_reset` 0, `game_over` 0, `winner` 00, `fighting` 1.
- Pending capture, FIGHT only:
  - `pN_pend` is set on any cycle with `pN_hit_req`.
  - `pN_unblk` is set if any captured request in the frame had `pN_hit_blocked`=0; an unblocked hit dominates the frame.
  - Requests in other states are ignored.
- Resolution on a `frame_tick` in FIGHT, per player, independently and in the same cycle:
  - The effective request is the pending flag OR the current-cycle request.
  - If the player has a request and cooldown is 0:
    - If the hit is blocked-only and block count > 0: stunmode 10, block count −1.
    - Otherwise (unblocked, or guard break when block count is 0): stunmode 01, health count −1.
    - Cooldown loads `HIT_COOLDOWN`.
  - Else if cooldown > 0: cooldown −1 and the request is dropped.
  - Pending flags clear on every frame tick.
- Counts saturate at 0 and never wrap.
- KO detection, evaluated on the post-update counts of the resolving tick:
  - Any health count 0: next state KO_DELAY.
  - `winner` is 01 if only P2 is at 0, 10 if only P1 is at 0, 11 if both (a simultaneous trade is a draw).
  - The delay counter loads `ROUND_END_DELAY`.
- KO_DELAY:
  - Decrement on each `frame_tick`.
  - Move to GAME_OVER on the tick where the counter reaches 0.
  - No hits are resolved.
- GAME_OVER:
  - `game_over`=1; `winner` is held.
  - `start` moves the FSM to CLEAR.
- CLEAR, one cycle:
  - `status_reset`=1.
  - Counts reload to 3; cooldowns, pendings and `winner` clear.
  - Next state FIGHT.
- `start` outside GAME_OVER is ignored.
- `reset` at any point, including mid-KO_DELAY, forces the reset values on the next edge. No `status_reset` pulse is issued because the status registers reload on the same reset.

## Timing
- A hit request at cycle n with `frame_tick` also at n produces stunmode at cycle n+1, high for exactly one cycle, then 00.
- The mirrored counts update at n+1, coincident with stunmode.
- `fighting` drops at n+1 on a KO tick.
- `game_over` rises one cycle after the last KO_DELAY tick.
- From `start` at cycle m:
  - CLEAR at m+1 with `status_reset` high;
  - FIGHT at m+2, counts 3.
- Maximum one stunmode pulse per player per frame.
- Cooldown=0 with `HIT_COOLDOWN`=0 permits one hit per frame.

## Test plan
- Basic hurt, reset then P1 hurt: `p1_hit_req`=1, `p1_hit_blocked`=0 on a tick → `p1_stunmode`=01 for 1 cycle, `p1_health` 3→2, P2 outputs unchanged.
- Guard break, `HIT_COOLDOWN`=0: four blocked P2 hits on successive ticks → stunmode 10,10,10,01; `p2_block` 3→0; `p2_health` 3→2.
- Cooldown, `HIT_COOLDOWN`=2: P1 hit on every tick → pulses on ticks 0 and 3 only; hits on ticks 1–2 are dropped.
- Mixed frame: within one frame, a P1 blocked request followed by an unblocked request, then a tick → stunmode 01, block count unchanged.
- Trade KO: both players at health 1, both hit on the same tick → both stunmode 01, `winner`=11; `game_over` after `ROUND_END_DELAY` ticks.
- Restart: `start` in GAME_OVER → 1-cycle `status_reset`, counts 3, `winner` 00, `fighting`=1. Reset asserted mid-KO_DELAY → FIGHT next cycle with no `status_reset` pulse.
